// File: rtl/wb_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load writeback,
// with a 32-entry pending-write scoreboard. Macro WB_ZERO_GUARD_EN suppresses writes to register 0.
module wb_write_arbiter (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Stall,
    input  logic        Valid0,
    input  logic [4:0]  Addr0,
    input  logic [31:0] Data0,
    output logic        Ready0,
    input  logic        Valid1,
    input  logic [4:0]  Addr1,
    input  logic [31:0] Data1,
    output logic        Ready1,
    input  logic        Reserve_En,
    input  logic [4:0]  Reserve_Addr,
    output logic [4:0]  Awr,
    output logic [31:0] Din,
    output logic        WrEn,
    output logic [31:0] Pending
);

    logic        prio_r;
    logic [4:0]  awr_r;
    logic [31:0] din_r;
    logic        wren_r;
    logic [31:0] pending_r;

    logic        grant0_s;
    logic        grant1_s;
    logic        xfer_s;
    logic [4:0]  gnt_addr_s;
    logic [31:0] gnt_data_s;
    logic        wr_en_next_s;
    logic [31:0] pending_next_s;

    // Grant selection: a lone requester wins, a contended cycle goes to the prio port.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (!Stall) begin
            if (Valid0 && Valid1) begin
                if (prio_r) begin
                    grant1_s = 1'b1;
                end else begin
                    grant0_s = 1'b1;
                end
            end else if (Valid0) begin
                grant0_s = 1'b1;
            end else if (Valid1) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b0;
            end
        end else begin
            grant0_s = 1'b0;
        end
    end

    // Granted request payload and next write-enable.
    always_comb begin
        xfer_s = grant0_s | grant1_s;
        if (grant1_s) begin
            gnt_addr_s = Addr1;
            gnt_data_s = Data1;
        end else begin
            gnt_addr_s = Addr0;
            gnt_data_s = Data0;
        end
`ifdef WB_ZERO_GUARD_EN
        wr_en_next_s = xfer_s && (gnt_addr_s != 5'd0);
`else
        wr_en_next_s = xfer_s;
`endif
    end

    // Scoreboard next state: clear on transfer first so a same-cycle reserve wins.
    always_comb begin
        pending_next_s = pending_r;
        if (xfer_s) begin
            pending_next_s[gnt_addr_s] = 1'b0;
        end else begin
            pending_next_s = pending_r;
        end
        if (Reserve_En && (Reserve_Addr != 5'd0)) begin
            pending_next_s[Reserve_Addr] = 1'b1;
        end else begin
            pending_next_s[0] = 1'b0;
        end
        pending_next_s[0] = 1'b0;
    end

    // Priority, write stage and scoreboard registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            prio_r    <= 1'b0;
            awr_r     <= 5'd0;
            din_r     <= 32'd0;
            wren_r    <= 1'b0;
            pending_r <= 32'd0;
        end else begin
            wren_r    <= wr_en_next_s;
            pending_r <= pending_next_s;
            if (xfer_s) begin
                prio_r <= grant0_s;
                awr_r  <= gnt_addr_s;
                din_r  <= gnt_data_s;
            end
        end
    end

    assign Ready0  = grant0_s;
    assign Ready1  = grant1_s;
    assign Awr     = awr_r;
    assign Din     = din_r;
    assign WrEn    = wren_r;
    assign Pending = pending_r;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard testbench for wb_write_arbiter: directed scenarios followed by randomized traffic.
module tb_wb_write_arbiter;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Stall = 1'b0;
    logic        Valid0 = 1'b0;
    logic [4:0]  Addr0 = 5'd0;
    logic [31:0] Data0 = 32'd0;
    logic        Ready0;
    logic        Valid1 = 1'b0;
    logic [4:0]  Addr1 = 5'd0;
    logic [31:0] Data1 = 32'd0;
    logic        Ready1;
    logic        Reserve_En = 1'b0;
    logic [4:0]  Reserve_Addr = 5'd0;
    logic [4:0]  Awr;
    logic [31:0] Din;
    logic        WrEn;
    logic [31:0] Pending;

    wb_write_arbiter dut (
        .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall),
        .Valid0(Valid0), .Addr0(Addr0), .Data0(Data0), .Ready0(Ready0),
        .Valid1(Valid1), .Addr1(Addr1), .Data1(Data1), .Ready1(Ready1),
        .Reserve_En(Reserve_En), .Reserve_Addr(Reserve_Addr),
        .Awr(Awr), .Din(Din), .WrEn(WrEn), .Pending(Pending)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        en;
        logic [4:0]  awr;
        logic [31:0] din;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state
    int          fav_port = 0;
    bit          m_pend[32];
    logic [4:0]  m_awr = 5'd0;
    logic [31:0] m_din = 32'd0;
    int          last_grant = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pend_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_reset();
        fav_port = 0;
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_awr = 5'd0;
        m_din = 32'd0;
        q.delete();
    endtask

    // One clock cycle: drive, check combinational grant and scoreboard, predict the write stage.
    task automatic cycle(input logic st, input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic re, input logic [4:0] ra);
        exp_t e;
        int g;
        logic [4:0] ga;
        @(negedge Clk);
        Stall = st; Valid0 = v0; Addr0 = a0; Data0 = d0;
        Valid1 = v1; Addr1 = a1; Data1 = d1;
        Reserve_En = re; Reserve_Addr = ra;
        #1;
        g = -1;
        if (!st) begin
            if (v0 && v1) g = fav_port;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
        end
        chk("ready0", {31'd0, Ready0}, {31'd0, g == 0});
        chk("ready1", {31'd0, Ready1}, {31'd0, g == 1});
        chk("pending", Pending, pend_vec());
        e.en = 1'b0;
        if (g >= 0) begin
            ga = (g == 0) ? a0 : a1;
            m_awr = ga;
            m_din = (g == 0) ? d0 : d1;
            fav_port = 1 - g;
            m_pend[ga] = 1'b0;
`ifdef WB_ZERO_GUARD_EN
            e.en = (ga != 5'd0);
`else
            e.en = 1'b1;
`endif
        end
        if (re && ra != 5'd0) m_pend[ra] = 1'b1;
        e.awr = m_awr;
        e.din = m_din;
        q.push_back(e);
        last_grant = g;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    // Assert reset asynchronously mid-cycle and check outputs clear without a clock edge.
    task automatic do_reset();
        @(negedge Clk);
        #3;
        Rst_n = 1'b0;
        Valid0 = 1'b0; Valid1 = 1'b0; Reserve_En = 1'b0; Stall = 1'b0;
        #1;
        chk("rst_wren", {31'd0, WrEn}, 32'd0);
        chk("rst_awr", {27'd0, Awr}, 32'd0);
        chk("rst_din", Din, 32'd0);
        chk("rst_pending", Pending, 32'd0);
        model_reset();
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    // Monitor: after every active edge, pop the prediction for the write stage and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #2;
            if (Rst_n && q.size() > 0) begin
                e = q.pop_front();
                chk("wren", {31'd0, WrEn}, {31'd0, e.en});
                chk("awr", {27'd0, Awr}, {27'd0, e.awr});
                chk("din", Din, e.din);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic        rv0, rv1;
        logic [4:0]  ra0, ra1;
        logic [31:0] rd0, rd1;
        model_reset();
        repeat (2) @(negedge Clk);
        #1;
        chk("init_wren", {31'd0, WrEn}, 32'd0);
        chk("init_pending", Pending, 32'd0);
        Rst_n = 1'b1;

        // single port-0 write
        cycle(1'b0, 1'b1, 5'd5, 32'h0000_00AA, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        idle(2);

        // contended writes alternate from reset priority
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0);
        idle(1);

        // stall with both requesting
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0);
        cycle(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0);
        idle(1);

        // scoreboard set/clear collision
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h98, 1'b0, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
        idle(1);

        // write to register 0
        cycle(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        idle(2);

        // reset in the cycle after a transfer
        cycle(1'b0, 1'b1, 5'd12, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 1'b1, 5'd20);
        do_reset();
        idle(2);

        // randomized traffic with held requests
        rv0 = 1'b0; rv1 = 1'b0; ra0 = 5'd0; ra1 = 5'd0; rd0 = 32'd0; rd1 = 32'd0;
        for (int i = 0; i < 500; i++) begin
            if (!rv0 || last_grant == 0) begin
                rv0 = ($urandom_range(0, 2) != 0);
                ra0 = 5'($urandom_range(0, 15));
                rd0 = $urandom;
            end
            if (!rv1 || last_grant == 1) begin
                rv1 = ($urandom_range(0, 2) != 0);
                ra1 = 5'($urandom_range(0, 15));
                rd1 = $urandom;
            end
            cycle(($urandom_range(0, 4) == 0), rv0, ra0, rd0, rv1, ra1, rd1,
                  ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 15)));
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Shares the register file's single write port (Awr/Din/WrEn) between two writeback requesters: port 0 (ALU result) and port 1 (memory load data). It uses round-robin arbitration with valid/ready handshakes. Granted writes are registered one cycle before they reach the register file. A 32-entry pending scoreboard records destination registers that have an outstanding write, so issue logic can stall on read-after-write hazards.

## Interface
- No parameters; data width fixed at 32, address width fixed at 5.
- Clk  in  1  single clock; all state updates on rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Stall  in  1  when high, no request is granted this cycle.
- Valid0  in  1  port 0 request.
- Addr0  in  5  port 0 destination register.
- Data0  in  32  port 0 write data.
- Ready0  out  1  port 0 grant (combinational).
- Valid1, Addr1, Data1, Ready1  same as port 0, for port 1.
- Reserve_En  in  1  issue logic marks Reserve_Addr as pending.
- Reserve_Addr  in  5  register being reserved.
- Awr  out  5  register file write address (registered).
- Din  out  32  register file write data (registered).
- WrEn  out  1  register file write enable (registered).
- Pending  out  32  bit i high means register i has an outstanding write.

## Operation
- Handshake: a transfer on port k occurs at a rising edge when Validk && Readyk. Requesters hold Addr/Data stable while Valid is high and not granted. Valid must not drop before the grant.
- Grant rule when Stall=0:
  - Only one Valid high: that port is granted.
  - Both Valid high: the port named by priority bit Prio is granted.
  - At most one Ready is high in any cycle.
- Grant rule when Stall=1: both Ready are low.
- Prio update: after any transfer, Prio points to the port that was not granted. With no transfer, Prio holds.
- Write stage: on a transfer, Awr/Din take the granted Addr/Data and WrEn goes high for exactly that next cycle. With no transfer, WrEn goes low and Awr/Din hold their previous values.
- Scoreboard, applied per rising edge:
  - Reserve_En=1 sets Pending[Reserve_Addr].
  - A transfer clears Pending[granted Addr].
  - If a set and a clear hit the same address in the same cycle, the set wins, because the newer instruction owns the register.
  - Reserve_Addr=0 is ignored, so Pending[0] is always 0.
- An unreserved destination may still be written; the clear is a no-op.

## Timing
- Reset values: WrEn=0, Awr=0, Din=0, Pending=0, Prio=0 (port 0 favoured). Ready0/Ready1 follow the combinational rule from reset-state Prio.
- Latency: transfer at edge N, then WrEn/Awr/Din valid during cycle N+1, then the register file writes at edge N+1.
- Pending clears at edge N, the same edge as the transfer.
- Throughput: one write per cycle. Back-to-back transfers produce continuous WrEn.
- Reset asserted mid-operation:
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - An in-flight registered write is dropped.
  - Requesters must re-present after Rst_n rises.
- Stall rising with Valid held: no transfer, Prio holds, and the pending write from the previous cycle still completes (WrEn high one cycle).

## Configuration
- Macro WB_ZERO_GUARD_EN.
- Defined: a transfer with Addr=0 completes its handshake and advances Prio, but WrEn stays 0 in the following cycle, so register 0 is never written.
- Undefined: Addr=0 writes are forwarded like any other address (WrEn=1, Awr=0).

## Test plan
- Reset, then Valid0=1, Addr0=5, Data0=0x0000_00AA for one cycle → Ready0=1; next cycle WrEn=1, Awr=5, Din=0xAA; the cycle after, WrEn=0.
- Both Valid held with Addr0=3/Data0=0x11 and Addr1=7/Data1=0x22 → grants alternate port0, port1, port0 starting from reset; WrEn stays high continuously; Awr sequence 3,7,3.
- Stall=1 for 3 cycles with both Valid high → Ready0=Ready1=0 and WrEn=0 throughout; Prio unchanged; when Stall=0, the port 0 grant occurs first.
- Reserve_En=1, Reserve_Addr=9 → Pending[9]=1. Later, a port 1 write to 9 in the same cycle as Reserve_Addr=9 → Pending[9] stays 1. A further write to 9 without a reserve → Pending[9]=0.
- With WB_ZERO_GUARD_EN defined, a port 0 write to Addr0=0, Data0=0xFFFF_FFFF → Ready0=1, WrEn=0 the next cycle. Without the macro → WrEn=1, Awr=0.
- Rst_n pulled low in the cycle after a transfer → WrEn, Awr, Din and Pending go to 0 asynchronously; no write occurs.
